// File: rtl/iir1_inverse_if.sv
// Handshake bundle between the iir1_inverse deconvolver and whoever feeds and drains it.
// The master side supplies y samples and coefficients; the slave side returns x and flags.
interface iir1_inverse_if #(
   parameter int YW = 32,
   parameter int AW = 8,
   parameter int BW = 8,
   parameter int XW = 16
) ();
   logic                 clear;
   logic signed [AW-1:0] a;
   logic signed [BW-1:0] b;
   logic signed [YW-1:0] y_in;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [XW-1:0] x_out;
   logic                 inexact;
   logic                 sat;
   logic                 div0;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output clear, a, b, y_in, in_valid, out_ready,
      input  in_ready, x_out, inexact, sat, div0, out_valid
   );

   modport slave (
      input  clear, a, b, y_in, in_valid, out_ready,
      output in_ready, x_out, inexact, sat, div0, out_valid
   );
endinterface

// File: rtl/iir1_inverse.sv
// Inverse of y(n) = a*y(n-1) + b*x(n): recovers x(n) = (y(n) - a*y(n-1)) / b
// with one multiply-subtract cycle followed by a bit-serial restoring divider.
module iir1_inverse #(
   parameter int YW = 32,
   parameter int AW = 8,
   parameter int BW = 8,
   parameter int XW = 16
) (
   input logic           clk,
   input logic           rst_n,
   iir1_inverse_if.slave bus
);
   localparam int EW = YW + AW + 1;
   localparam int CW = $clog2(EW + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(EW);
   localparam logic [EW-1:0] QMAX = {{(EW-XW+1){1'b0}}, {(XW-1){1'b1}}};
   localparam logic [EW-1:0] QMIN = {{(EW-XW){1'b0}}, 1'b1, {(XW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t               state, state_next;
   logic signed [YW-1:0] y_reg, y_prev;
   logic signed [AW-1:0] a_reg;
   logic signed [BW-1:0] b_reg;
   logic signed [YW+AW-1:0] prod;
   logic [EW-1:0]        y_ext, p_ext, e_full, e_mag;
   logic                 e_neg, q_neg;
   logic [BW:0]          b_ext, dsr_n, dsr, rem, rem_n, diff;
   logic [BW+1:0]        shifted;
   logic                 qbit;
   logic [EW-1:0]        dvd, quo;
   logic [CW-1:0]        cnt;
   logic signed [XW-1:0] fin_x, x_reg;
   logic                 fin_sat, inexact_reg, sat_reg, div0_reg;

   // e is formed at full precision so the subtraction can never wrap.
   assign prod   = a_reg * y_prev;
   assign y_ext  = {{(EW-YW){y_reg[YW-1]}}, y_reg};
   assign p_ext  = {{(EW-YW-AW){prod[YW+AW-1]}}, prod};
   assign e_full = y_ext - p_ext;
   assign e_mag  = e_full[EW-1] ? -e_full : e_full;

   assign b_ext = {b_reg[BW-1], b_reg};
   assign dsr_n = b_reg[BW-1] ? -b_ext : b_ext;

   assign shifted = {rem, dvd[EW-1]};
   assign qbit    = (shifted >= {1'b0, dsr});
   assign diff    = shifted[BW:0] - dsr;
   assign rem_n   = qbit ? diff : shifted[BW:0];

   assign q_neg = e_neg ^ b_reg[BW-1];

   // Quotient magnitude is signed and clipped to the x range here.
   always_comb begin
      fin_x   = '0;
      fin_sat = 1'b0;
      if (!q_neg && (quo > QMAX)) begin
         fin_x   = {1'b0, {(XW-1){1'b1}}};
         fin_sat = 1'b1;
      end else if (q_neg && (quo > QMIN)) begin
         fin_x   = {1'b1, {(XW-1){1'b0}}};
         fin_sat = 1'b1;
      end else if (q_neg) begin
         fin_x = -quo[XW-1:0];
      end else begin
         fin_x = quo[XW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid) state_next = MUL;
         MUL:     state_next = DIV;
         DIV:     if (cnt == CNT_LAST) state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = rst_n && (state == IDLE);
      bus.out_valid = (state == DONE);
      bus.x_out     = x_reg;
      bus.inexact   = inexact_reg;
      bus.sat       = sat_reg;
      bus.div0      = div0_reg;
   end

   // The DIV state spends EW cycles on quotient bits and one more formatting the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_reg       <= '0;
         y_prev      <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         e_neg       <= 1'b0;
         dvd         <= '0;
         quo         <= '0;
         dsr         <= '0;
         rem         <= '0;
         cnt         <= '0;
         x_reg       <= '0;
         inexact_reg <= 1'b0;
         sat_reg     <= 1'b0;
         div0_reg    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  y_reg <= bus.y_in;
                  a_reg <= bus.a;
                  b_reg <= bus.b;
               end else if (bus.clear) begin
                  y_prev <= '0;
               end
            end
            MUL: begin
               dvd    <= e_mag;
               e_neg  <= e_full[EW-1];
               dsr    <= dsr_n;
               rem    <= '0;
               quo    <= '0;
               cnt    <= '0;
               y_prev <= y_reg;
            end
            DIV: begin
               if (cnt == CNT_LAST) begin
                  if (b_reg == '0) begin
                     x_reg       <= '0;
                     sat_reg     <= 1'b0;
                     inexact_reg <= 1'b0;
                     div0_reg    <= 1'b1;
                  end else begin
                     x_reg       <= fin_x;
                     sat_reg     <= fin_sat;
                     inexact_reg <= (rem != '0);
                     div0_reg    <= 1'b0;
                  end
               end else begin
                  dvd <= {dvd[EW-2:0], 1'b0};
                  quo <= {quo[EW-2:0], qbit};
                  rem <= rem_n;
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_iir1_inverse.sv
// Directed bench for iir1_inverse: hand-computed x values, flags, latency,
// back-pressure, clear and asynchronous reset behaviour.
module tb_iir1_inverse;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   passes = 0;

   iir1_inverse_if #(.YW(32), .AW(8), .BW(8), .XW(16)) bus ();

   iir1_inverse #(.YW(32), .AW(8), .BW(8), .XW(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic send(input logic signed [7:0] a, input logic signed [7:0] b,
                       input logic signed [31:0] y, input logic clr);
      @(negedge clk);
      bus.a = a; bus.b = b; bus.y_in = y; bus.clear = clr; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.clear    = 1'b0;
   endtask

   // Counts clocks from the accept edge; gives up after 200 so a stuck DUT still ends.
   task automatic wait_result(output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic run_sample(input logic signed [7:0] a, input logic signed [7:0] b,
                             input logic signed [31:0] y, output logic signed [15:0] x,
                             output logic [2:0] flags, output int lat);
      send(a, b, y, 1'b0);
      wait_result(lat);
      x     = bus.x_out;
      flags = {bus.inexact, bus.sat, bus.div0};
      handshake();
   endtask

   task automatic test_reset();
      bus.a = '0; bus.b = '0; bus.y_in = '0; bus.clear = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10)
         $display("[TB] FAIL reset_handshake: got %b expected 10", {bus.in_ready, bus.out_valid});
      else passes++;
      checks++;
      if (bus.x_out !== 16'sd0 || {bus.inexact, bus.sat, bus.div0} !== 3'b000)
         $display("[TB] FAIL reset_outputs: got x=%0d flags=%b expected x=0 flags=000",
                  bus.x_out, {bus.inexact, bus.sat, bus.div0});
      else passes++;
   endtask

   task automatic test_basic();
      logic signed [31:0] ys [3] = '{32'sd12, -32'sd12, -32'sd40};
      logic signed [15:0] xs [3] = '{-16'sd3, 16'sd9, 16'sd4};
      logic signed [15:0] x;
      logic [2:0]         flags;
      int                 lat;
      for (int i = 0; i < 3; i++) begin
         run_sample(8'sd2, -8'sd4, ys[i], x, flags, lat);
         checks++;
         if (x !== xs[i]) $display("[TB] FAIL basic_x[%0d]: got %0d expected %0d", i, x, xs[i]);
         else passes++;
         checks++;
         if (flags !== 3'b000) $display("[TB] FAIL basic_flags[%0d]: got %b expected 000", i, flags);
         else passes++;
         checks++;
         if (lat !== 43) $display("[TB] FAIL basic_latency[%0d]: got %0d expected 43", i, lat);
         else passes++;
      end
   endtask

   task automatic test_rounding();
      logic signed [31:0] ys [2] = '{32'sd13, -32'sd13};
      logic signed [15:0] xs [2] = '{-16'sd3, 16'sd3};
      logic signed [15:0] x;
      logic [2:0]         flags;
      int                 lat;
      for (int i = 0; i < 2; i++) begin
         run_sample(8'sd0, -8'sd4, ys[i], x, flags, lat);
         checks++;
         if (x !== xs[i] || flags !== 3'b100)
            $display("[TB] FAIL rounding[%0d]: got x=%0d flags=%b expected x=%0d flags=100",
                     i, x, flags, xs[i]);
         else passes++;
      end
   endtask

   task automatic test_saturation();
      logic signed [31:0] ys [2] = '{32'sd100000, -32'sd100000};
      logic signed [15:0] xs [2] = '{16'sh7FFF, 16'sh8000};
      logic signed [15:0] x;
      logic [2:0]         flags;
      int                 lat;
      for (int i = 0; i < 2; i++) begin
         run_sample(8'sd0, 8'sd1, ys[i], x, flags, lat);
         checks++;
         if (x !== xs[i] || flags !== 3'b010)
            $display("[TB] FAIL saturation[%0d]: got x=%0d flags=%b expected x=%0d flags=010",
                     i, x, flags, xs[i]);
         else passes++;
      end
   endtask

   task automatic test_div0();
      logic signed [15:0] x;
      logic [2:0]         flags;
      int                 lat;
      run_sample(8'sd0, 8'sd0, 32'sd50, x, flags, lat);
      checks++;
      if (x !== 16'sd0 || flags !== 3'b001)
         $display("[TB] FAIL div0_result: got x=%0d flags=%b expected x=0 flags=001", x, flags);
      else passes++;
      checks++;
      if (lat !== 43) $display("[TB] FAIL div0_latency: got %0d expected 43", lat);
      else passes++;
      run_sample(8'sd1, 8'sd1, 32'sd0, x, flags, lat);
      checks++;
      if (x !== -16'sd50 || flags !== 3'b000)
         $display("[TB] FAIL div0_history: got x=%0d flags=%b expected x=-50 flags=000", x, flags);
      else passes++;
   endtask

   task automatic test_b_min();
      logic signed [15:0] x;
      logic [2:0]         flags;
      int                 lat;
      run_sample(8'sd0, -8'sd128, -32'sd1000, x, flags, lat);
      checks++;
      if (x !== 16'sd7 || flags !== 3'b100)
         $display("[TB] FAIL b_min: got x=%0d flags=%b expected x=7 flags=100", x, flags);
      else passes++;
   endtask

   task automatic test_back_to_back();
      int lat;
      send(8'sd0, 8'sd3, 32'sd30, 1'b0);
      wait_result(lat);
      @(negedge clk);
      bus.a = 8'sd1; bus.b = 8'sd1; bus.y_in = 32'sd100; bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.x_out !== 16'sd10 || bus.in_ready !== 1'b0 ||
             {bus.inexact, bus.sat, bus.div0} !== 3'b000)
            $display("[TB] FAIL hold[%0d]: got valid=%b x=%0d ready=%b flags=%b expected 1 10 0 000",
                     i, bus.out_valid, bus.x_out, bus.in_ready, {bus.inexact, bus.sat, bus.div0});
         else passes++;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01)
         $display("[TB] FAIL after_handshake: got valid,ready=%b expected 01", {bus.out_valid, bus.in_ready});
      else passes++;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b0) $display("[TB] FAIL pending_accept: got ready=%b expected 0", bus.in_ready);
      else passes++;
      wait_result(lat);
      checks++;
      if (bus.x_out !== 16'sd70 || lat !== 43)
         $display("[TB] FAIL pending_result: got x=%0d lat=%0d expected x=70 lat=43", bus.x_out, lat);
      else passes++;
      handshake();
   endtask

   task automatic test_reset_mid_div();
      logic signed [15:0] x;
      logic [2:0]         flags;
      int                 lat;
      send(8'sd0, 8'sd1, 32'sd5, 1'b0);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.x_out !== 16'sd0 || {bus.inexact, bus.sat, bus.div0, bus.out_valid, bus.in_ready} !== 5'b00000)
         $display("[TB] FAIL async_reset: got x=%0d flags,valid,ready=%b expected x=0 00000",
                  bus.x_out, {bus.inexact, bus.sat, bus.div0, bus.out_valid, bus.in_ready});
      else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      run_sample(8'sd2, 8'sd1, 32'sd7, x, flags, lat);
      checks++;
      if (x !== 16'sd7 || flags !== 3'b000)
         $display("[TB] FAIL reset_history: got x=%0d flags=%b expected x=7 flags=000", x, flags);
      else passes++;
   endtask

   task automatic test_clear();
      logic signed [15:0] x;
      logic [2:0]         flags;
      int                 lat;
      run_sample(8'sd0, 8'sd1, 32'sd9, x, flags, lat);
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      run_sample(8'sd2, 8'sd1, 32'sd7, x, flags, lat);
      checks++;
      if (x !== 16'sd7) $display("[TB] FAIL clear_idle: got %0d expected 7", x);
      else passes++;
      send(8'sd1, 8'sd1, 32'sd20, 1'b1);
      wait_result(lat);
      checks++;
      if (bus.x_out !== 16'sd13) $display("[TB] FAIL clear_vs_accept: got %0d expected 13", bus.x_out);
      else passes++;
      handshake();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_div0();
      test_b_min();
      test_back_to_back();
      test_reset_mid_div();
      test_clear();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
